itof_arbiter: RTL and testbench

//  Shares one combinational itof converter (int32 -> fp32) between NREQ requesters.

---
 rtl/itof_arbiter_pkg.sv | 11 +
 rtl/itof_arbiter_if.sv | 25 ++
 rtl/itof.sv | 28 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/itof_arbiter.sv | 67 ++++++
 tb/tb_itof_arbiter.sv | 253 +++++++++++++++++++++++++
 6 files changed

// File: rtl/itof_arbiter_pkg.sv
// Shared constants, types and helpers for the itof sharing block and its siblings.
package itof_arbiter_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // Tag width for a requester index; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/itof_arbiter_if.sv
// Requester-side and result-side handshake bundle of the shared itof unit.
interface itof_arbiter_if
  import itof_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = clog2_min1(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [31:0]        out_y;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  modport master (
    output req_valid, req_x, out_ready,
    input  req_ready, out_valid, out_y, out_id
  );

  modport slave (
    input  req_valid, req_x, out_ready,
    output req_ready, out_valid, out_y, out_id
  );
endinterface

// File: rtl/itof.sv
// Combinational int32 -> fp32 conversion, round half-up on the first dropped bit.
module itof
  import itof_arbiter_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  lz;
  logic [23:0] rnd;
  logic [7:0]  expo;

  always_comb begin
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;
    lz   = '0;
    // Ascending scan: the last hit is the leading one.
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lz = 5'(31 - i);
    end
    norm = mag << lz;
    rnd  = {1'b0, norm[30:8]} + {23'd0, norm[7]};
    expo = 8'd158 - {3'd0, lz} + {7'd0, rnd[23]};
    y    = (mag == 32'd0) ? FP32_ZERO : {sign, expo, rnd[22:0]};
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid,
  output logic            any
);
  logic           found;
  logic [IDW-1:0] hit;
  int             idx;

  always_comb begin
    found = 1'b0;
    hit   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        hit   = IDW'(idx);
      end
    end
    gid   = hit;
    any   = found & en;
    grant = any ? (NREQ'(1) << hit) : '0;
  end
endmodule

// File: rtl/itof_arbiter.sv
// Shares one itof converter among NREQ requesters through a round-robin, two-stage pipe.
module itof_arbiter
  import itof_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  output logic           busy,
  itof_arbiter_if.slave  bus
);
  typedef struct packed {
    logic           valid;
    logic [31:0]    data;
    logic [IDW-1:0] id;
  } stage_t;

  stage_t         s1, s2;
  logic [IDW-1:0] rr_ptr;
  logic           adv1, adv2, en, any;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gid;
  logic [31:0]    x_g, y_s1;

  assign adv2 = !s2.valid | bus.out_ready;
  assign adv1 = !s1.valid | adv2;
  assign en   = adv1 & !flush & !rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (en),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  assign x_g = bus.req_x[32*int'(gid) +: 32];

  itof u_itof (
    .x (s1.data),
    .y (y_s1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      s1.valid <= 1'b0;
      s2.valid <= 1'b0;
    end else begin
      if (adv2) s2 <= '{valid: s1.valid, data: y_s1, id: s1.id};
      if (adv1) s1 <= '{valid: any, data: x_g, id: gid};
      if (any) rr_ptr <= (int'(gid) == int'(NREQ) - 1) ? '0 : gid + IDW'(1);
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = s2.valid;
  assign bus.out_y     = s2.data;
  assign bus.out_id    = s2.id;
  assign busy          = s1.valid | s2.valid;
endmodule

// File: tb/tb_itof_arbiter.sv
// Directed bench: accepted operands push expected results; a monitor pops and compares.
module tb_itof_arbiter;
  import itof_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic clk = 1'b0;
  logic rst, flush, busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  itof_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  itof_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]    y;
    logic [IDW-1:0] id;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  logic [31:0]    exp_y[NREQ];
  logic           prev_hold = 1'b0;
  logic [31:0]    prev_y;
  logic [IDW-1:0] prev_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst || flush) begin
      check("no grant during rst/flush", 32'(bus.req_ready), 32'd0);
      sb.delete();
    end else begin
      check("req_ready one-hot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      check("no grant to invalid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
      if (prev_hold) begin
        check("stall keeps out_valid", 32'(bus.out_valid), 32'd1);
        check("stall keeps out_y", bus.out_y, prev_y);
        check("stall keeps out_id", 32'(bus.out_id), 32'(prev_id));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result y", bus.out_y, e.y);
          check("result id", 32'(bus.out_id), 32'(e.id));
          check("latency >= 2", 32'((cyc - e.cyc) >= 2), 32'd1);
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{y: exp_y[i], id: IDW'(i), cyc: cyc});
      end
    end
    prev_hold = !rst && !flush && bus.out_valid && !bus.out_ready;
    prev_y    = bus.out_y;
    prev_id   = bus.out_id;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [31:0] x0, input logic [31:0] e0,
                       input logic [31:0] x1, input logic [31:0] e1);
    bus.req_valid = v;
    bus.req_x     = {x1, x0};
    exp_y[0]      = e0;
    exp_y[1]      = e1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < budget) begin
      next();
      n++;
    end
    check("drain within budget", 32'(sb.size()), 32'd0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b11, 32'd1, 32'h3F80_0000, 32'd2, 32'h4000_0000);
    repeat (3) next();
    smp();
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_y", bus.out_y, 32'd0);
    check("reset out_id", 32'(bus.out_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);

    // Single op: latency two cycles.
    next();
    rst = 1'b0;
    drive(2'b01, 32'd1, 32'h3F80_0000, 32'd0, 32'd0);
    smp();
    check("t1 grant cycle0", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    smp();
    check("t1 no early out_valid", 32'(bus.out_valid), 32'd0);
    next();
    smp();
    check("t1 out_valid cycle2", 32'(bus.out_valid), 32'd1);
    check("t1 out_y", bus.out_y, 32'h3F80_0000);
    check("t1 out_id", 32'(bus.out_id), 32'd0);
    drain(10);

    // Alternating grants from rr_ptr=0.
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    drive(2'b11, 32'hFFFF_FFFF, 32'hBF80_0000, 32'h8000_0000, 32'hCF00_0000);
    for (int k = 0; k < 6; k++) begin
      smp();
      check("t2 grant alternates", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2) begin
        check("t2 result every cycle", 32'(bus.out_valid), 32'd1);
        check("t2 interleaved id", 32'(bus.out_id), 32'(k % 2));
      end
      next();
    end
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    drain(10);

    // Backpressure with both stages full.
    bus.out_ready = 1'b0;
    drive(2'b01, 32'h7FFF_FFFF, 32'h4F00_0000, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      smp();
      if (k < 2) begin
        check("t3 fill grant", 32'(bus.req_ready), 32'd1);
      end else begin
        check("t3 stalled req_ready", 32'(bus.req_ready), 32'd0);
        check("t3 stalled out_y", bus.out_y, 32'h4F00_0000);
        check("t3 busy", 32'(busy), 32'd1);
      end
      next();
    end
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    smp();
    check("t3 drain first", 32'(bus.out_valid), 32'd1);
    next();
    smp();
    check("t3 drain second", 32'(bus.out_valid), 32'd1);
    next();
    smp();
    check("t3 drained", 32'(bus.out_valid), 32'd0);
    check("t3 no loss", 32'(sb.size()), 32'd0);

    // Zero and half-up rounding back-to-back.
    next();
    drive(2'b01, 32'd0, 32'h0000_0000, 32'd0, 32'd0);
    smp();
    check("t4 grant zero", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b01, 32'd16777217, 32'h4B80_0001, 32'd0, 32'd0);
    smp();
    check("t4 grant round", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    smp();
    check("t4 y zero", bus.out_y, 32'h0000_0000);
    next();
    smp();
    check("t4 y rounded", bus.out_y, 32'h4B80_0001);
    drain(10);

    // Flush with both stages full.
    bus.out_ready = 1'b0;
    drive(2'b01, 32'd5, 32'h40A0_0000, 32'd0, 32'd0);
    smp();
    next();
    smp();
    next();
    flush = 1'b1;
    smp();
    check("t5 no grant in flush", 32'(bus.req_ready), 32'd0);
    check("t5 busy before flush", 32'(busy), 32'd1);
    next();
    flush = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    smp();
    check("t5 out_valid cleared", 32'(bus.out_valid), 32'd0);
    check("t5 busy cleared", 32'(busy), 32'd0);
    bus.out_ready = 1'b1;
    drive(2'b01, 32'd3, 32'h4040_0000, 32'd0, 32'd0);
    smp();
    check("t5 fresh grant", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    drain(10);

    // Reset mid-stream with rr_ptr=1.
    drive(2'b01, 32'd7, 32'h40E0_0000, 32'd0, 32'd0);
    smp();
    check("t6 grant before rst", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b11, 32'd7, 32'h40E0_0000, 32'd9, 32'h4110_0000);
    rst = 1'b1;
    smp();
    check("t6 req_ready in rst", 32'(bus.req_ready), 32'd0);
    next();
    rst = 1'b0;
    smp();
    check("t6 out_valid after rst", 32'(bus.out_valid), 32'd0);
    check("t6 out_y after rst", bus.out_y, 32'd0);
    check("t6 busy after rst", 32'(busy), 32'd0);
    check("t6 first grant to 0", 32'(bus.req_ready), 32'd1);
    next();
    drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
